// File: rtl/zl_conv_interleaver.sv
// Forney convolutional byte interleaver: I branches, branch j delays by j*M visits.
// Handshake is a combinational pass-through; all state advances only on a transfer.
module zl_conv_interleaver #(
    parameter int unsigned I     = 12,
    parameter int unsigned M     = 17,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in_req,
    output logic             data_in_ack,
    input  logic [WIDTH-1:0] data_in,
    output logic             data_out_req,
    input  logic             data_out_ack,
    output logic [WIDTH-1:0] data_out
);

    localparam int unsigned MEM_DEPTH = I * (I - 1) / 2 * M;
    localparam int unsigned PTR_W     = (((I - 1) * M) > 1) ? $clog2((I - 1) * M) : 1;
    localparam int unsigned ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned BR_W      = $clog2(I);

    logic              xfer_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] addr_c;
    logic [BR_W-1:0]   br_q, br_d;
    logic [ADDR_W-1:0] br_addr_c [I];
    logic [WIDTH-1:0]  mem_q [MEM_DEPTH];

    assign data_out_req = data_in_req;
    assign data_in_ack  = data_out_ack;
    assign xfer_c       = data_in_req && data_out_ack;

    // Branch 0 has no storage; its address slot is never used.
    assign br_addr_c[0] = '0;

    // Per-branch circular pointer over the branch's j*M-entry region.
    for (genvar g = 1; g < I; g++) begin : g_br
        localparam int unsigned LEN  = g * M;
        localparam int unsigned BASE = M * g * (g - 1) / 2;

        logic [PTR_W-1:0] ptr_q, ptr_d;

        always_comb begin
            ptr_d = ptr_q;
            if (xfer_c && (br_q == BR_W'(g))) begin
                ptr_d = (ptr_q == PTR_W'(LEN - 1)) ? '0 : ptr_q + PTR_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end

        assign br_addr_c[g] = ADDR_W'(BASE) + ADDR_W'(ptr_q);
    end

    // Branch commutator and write control.
    always_comb begin
        br_d    = br_q;
        wr_en_c = 1'b0;
        addr_c  = br_addr_c[br_q];
        if (xfer_c) begin
            br_d    = (br_q == BR_W'(I - 1)) ? '0 : br_q + BR_W'(1);
            wr_en_c = (br_q != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q <= '0;
        end else begin
            br_q <= br_d;
        end
    end

    // Storage array is deliberately not reset; read-before-write via async read.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[addr_c] <= data_in;
        end
    end

    assign data_out = (br_q == '0) ? data_in : mem_q[addr_c];

endmodule
